// File: rtl/fft_pkg.sv
// Shared constants, loader state encoding and FFT word packing for the
// fft_frame_loader slice.
package fft_pkg;

    localparam int N        = 64;
    localparam int ADDR_W   = 6;
    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 32;
    localparam int HALF_W   = DATA_W / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_HOLD
    } loader_state_e;

    // FFT load word: real part in the upper half, imaginary part in the lower.
    function automatic logic [DATA_W-1:0] pack_word(input logic [HALF_W-1:0] re,
                                                    input logic [HALF_W-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / FFT-load-out bundle of the frame loader. The master side is the
// surrounding system (sample source, FFT status, consumer); the slave side is
// the loader itself.
interface fft_frame_loader_if #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int ADDR_W   = fft_pkg::ADDR_W,
    parameter int DATA_W   = fft_pkg::DATA_W
) ();

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                fft_done;
    logic                frame_ack;
    logic                fft_reset;
    logic                fft_load;
    logic [ADDR_W-1:0]   fft_load_address;
    logic [DATA_W-1:0]   fft_data;
    logic                fft_start;
    logic                busy;
    logic                overflow;

    modport master (
        output sample_valid, sample, fft_done, frame_ack,
        input  fft_reset, fft_load, fft_load_address, fft_data, fft_start,
               busy, overflow
    );

    modport slave (
        input  sample_valid, sample, fft_done, frame_ack,
        output fft_reset, fft_load, fft_load_address, fft_data, fft_start,
               busy, overflow
    );

endinterface

// File: rtl/frame_bank_ram.sv
// Two frame banks in one array, addressed {bank, ptr}: one write port and one
// registered read port, written so synthesis maps it onto block RAM.
module frame_bank_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**(ADDR_W+1)];

    // Synchronous write and registered read.
    // NOTE: the array has no reset; a reset port would stop block-RAM inference,
    // and stale contents are never observed because bank_full gates every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame collector feeding a 64-point FFT: fills one bank while the
// other is reset/loaded/run/drained through the FFT, in strict order.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N         = fft_pkg::N,
    parameter int ADDR_W    = fft_pkg::ADDR_W,
    parameter int SAMPLE_W  = fft_pkg::SAMPLE_W,
    parameter int DATA_W    = fft_pkg::DATA_W,
    parameter int SIGNED_IN = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    fft_frame_loader_if.slave  bus
);

    loader_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                load_q, load_d;

    logic                accept;
    logic                wrap;
    logic                ack;
    logic [ADDR_W-1:0]   raddr_ptr;
    logic [SAMPLE_W-1:0] wdata;
    logic [SAMPLE_W-1:0] rdata;

    assign accept = bus.sample_valid && !bank_full_q[wr_bank_q];
    assign wrap   = accept && (wr_ptr_q == ADDR_W'(N - 1));
    assign ack    = (state_q == ST_HOLD) && bus.frame_ack;

    // Offset-binary to two's complement is a plain MSB flip.
    assign wdata = (SIGNED_IN != 0) ? bus.sample
                                    : {~bus.sample[SAMPLE_W-1], bus.sample[SAMPLE_W-2:0]};

    frame_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (wdata),
        .raddr_i ({rd_bank_q, raddr_ptr}),
        .rdata_o (rdata)
    );

    // Fill side: advance the write pointer, flip banks on wrap, flag drops.
    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_bank_d   = wr_bank_q;
        bank_full_d = bank_full_q;
        overflow_d  = overflow_q;
        if (ack) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // Applied after the clear so a set on the same bank wins.
        if (wrap) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (bus.sample_valid && bank_full_q[wr_bank_q]) begin
            overflow_d = 1'b1;
        end
    end

    // Drain FSM next state; the RAM read runs one cycle ahead of the load outputs.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_bank_d = rd_bank_q;
        raddr_ptr = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A wrap into the read bank starts the reset pulse right away.
                if (bank_full_q[rd_bank_q] || (wrap && (wr_bank_q == rd_bank_q))) begin
                    state_d = ST_RST;
                end
            end
            ST_RST: begin
                rd_ptr_d  = '0;
                raddr_ptr = '0;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                raddr_ptr = rd_ptr_q + 1'b1;
                rd_ptr_d  = rd_ptr_q + 1'b1;
                if (rd_ptr_q == ADDR_W'(N - 1)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.fft_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.frame_ack) begin
                    rd_bank_d = ~rd_bank_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_d = (state_d == ST_LOAD);

    // State registers for both sides.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            load_q      <= load_d;
        end
    end

    // rd_ptr_q and the RAM output are both registered, so they line up with load_q.
    assign bus.fft_reset        = (state_q == ST_RST);
    assign bus.fft_start        = (state_q == ST_START);
    assign bus.fft_load         = load_q;
    assign bus.fft_load_address = rd_ptr_q;
    assign bus.fft_data         = load_q ? pack_word(rdata, '0) : '0;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.overflow         = overflow_q;

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
Upstream feeder for the 64-point FFT controller. Collects a stream of real audio samples into ping-pong frame banks and offsets unsigned ADC codes to signed. Loads each full frame into the FFT through its load port, then issues start. Holds the frame until the downstream consumer acknowledges readout, so the FFT is always reset, loaded, run and drained in order.

Parameters:
N, 64, frame length in points; must be a power of two.
ADDR_W, 6, log2(N); sets the load_address width.
SAMPLE_W, 16, width of the input sample.
DATA_W, 32, FFT word: real part in [31:16], imaginary part in [15:0].
SIGNED_IN, 0, 0 = unsigned offset-binary input (subtract 2^(SAMPLE_W-1)); 1 = input already two's complement.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
sample_valid  in  1  one-cycle strobe; sample is valid this cycle.
sample  in  SAMPLE_W  audio sample.
fft_done  in  1  FFT controller done level.
frame_ack  in  1  one-cycle pulse from the consumer: output readout finished.
fft_reset  out  1  one-cycle pulse that clears the FFT counters.
fft_load  out  1  FFT write-enable for load data.
fft_load_address  out  ADDR_W  FFT load address, natural order 0..N-1.
fft_data  out  DATA_W  load word {signed sample, 16'h0000}.
fft_start  out  1  one-cycle start pulse.
busy  out  1  high whenever the FSM is not in IDLE.
overflow  out  1  sticky flag: a sample was dropped because both banks were full.

Behaviour:
Reset (reset_n low, async): FSM to IDLE; write pointer, write bank, read bank, bank_full[1:0] cleared. All outputs are 0, including overflow.

Fill side (runs in every FSM state):
- On sample_valid, if bank wr_bank is not full: store the converted sample at buf[wr_bank][wr_ptr]; wr_ptr++.
- When wr_ptr wraps N-1 -> 0: set bank_full[wr_bank]; toggle wr_bank.
- On sample_valid while bank_full[wr_bank] = 1: drop the sample, set overflow. wr_ptr does not advance.
- Conversion: if SIGNED_IN = 0, sample minus 2^(SAMPLE_W-1) computed as an MSB invert; no saturation needed.

Drain FSM (IDLE, RST, LOAD, START, WAIT, HOLD):
- IDLE: move to RST when bank_full[rd_bank] = 1.
- RST: fft_reset = 1 for exactly one cycle; move to LOAD with rd_ptr = 0.
- LOAD: exactly N cycles.
  - The buffer read is registered, so fft_load, fft_load_address and fft_data are registered and mutually aligned.
  - Address k carries the sample written k-th into that bank.
  - fft_load is high for exactly N consecutive cycles.
- START: fft_start = 1 for one cycle; this cycle begins one cycle after the last fft_load cycle.
- WAIT: hold until fft_done = 1, then go to HOLD.
- HOLD: hold until frame_ack. On frame_ack: clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
- IDLE re-evaluates on the next cycle, so back-to-back frames have a minimum one-cycle IDLE gap.

Ordering and simultaneous events:
- fft_done or frame_ack outside their waiting state is ignored.
- frame_ack in the same cycle as a fill-side wrap: the clear and the set apply to different banks. Both take effect.
- If the fill side is about to set bank_full on the same bank that is being cleared, the set wins.
- fft_start and fft_reset never assert in the same cycle.
- busy = (state != IDLE).

Latency and throughput:
- Last sample of a frame to the first fft_load cycle: 2 cycles (wrap, then RST, then LOAD).
- Sample loss is impossible while the consumer turnaround is shorter than N sample periods.

Reset mid-operation: async reset abandons the frame. Outputs drop low immediately and buffered data is discarded.

Decomposition:
- Shared package fft_pkg holds N, ADDR_W, DATA_W, the loader state enum, and the packing function {re, im}.
- One sub-module, frame_bank_ram: a dual-bank memory with 1 write port and 1 registered read port, indexed {bank, ptr}. It infers block RAM.

Test Plan:
1. Reset then 64 samples 0x8000..0x803F, SIGNED_IN = 0 -> fft_reset pulse, then 64 fft_load cycles with addresses 0..63 and fft_data = {0x0000..0x003F, 0x0000}, then fft_start one cycle after the last load.
2. Samples 0x0000 and 0xFFFF, SIGNED_IN = 0 -> fft_data[31:16] = 0x8000 and 0x7FFF.
3. Continuous samples during WAIT/HOLD -> the second bank fills without loss; after frame_ack the second frame loads with its exact values.
4. 130 samples with no frame_ack -> both banks full; overflow = 1 and stays high; after ack, the next frame contains samples 64..127 only.
5. fft_done held high plus frame_ack pulse during LOAD -> ignored; FSM reaches WAIT and needs a new fft_done and frame_ack.
6. reset_n asserted at the 30th LOAD cycle -> all outputs 0 asynchronously; after release, busy = 0 and a fresh 64 samples produce a normal frame.
